led_matrix_scan: RTL and testbench

//   Double-buffered 8x8 red/green LED matrix row scanner. Upstream pattern/animation logic writes a

---
 rtl/led_matrix_scan.sv | 116 +++++++++++
 tb/tb_led_matrix_scan.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/led_matrix_scan.sv
// Double-buffered 8x8 red/green LED matrix row scanner with inter-row blanking and frame-aligned swaps.
// Optional build macro LED_DIM_EN adds PWM brightness gating inside each row slot.
module led_matrix_scan #(
   parameter int SCAN_DIV  = 1000,
   parameter int BLANK_CYC = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [2:0] wr_row,
   input  logic [7:0] wr_r,
   input  logic [7:0] wr_g,
   input  logic       swap_req,
   input  logic [2:0] bright,
   output logic       swap_pend,
   output logic       swap_ack,
   output logic       frame_start,
   output logic [7:0] row,
   output logic [7:0] colR,
   output logic [7:0] colG
);

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
   } row_pix_t;

   row_pix_t    bank [2][8];
   logic        front_sel;
   logic [15:0] div;
   logic [2:0]  ridx;

   logic        last_div;
   logic        frame_end;
   logic        do_swap;
   logic        lit;
   logic        win;
   row_pix_t    cur;

   assign last_div  = (div == 16'(SCAN_DIV - 1));
   assign frame_end = last_div && (ridx == 3'd7);
   assign do_swap   = frame_end && (swap_pend || swap_req);
   assign lit       = (div >= 16'(BLANK_CYC));
   assign cur       = bank[front_sel][ridx];

`ifdef LED_DIM_EN
   // PWM phase restarts at the end of blanking so every slot gets the same duty pattern.
   logic [2:0] phase;
   assign phase = 3'(div - 16'(BLANK_CYC));
   assign win   = (phase <= bright);
`else
   logic unused_bright;
   assign unused_bright = ^bright;
   assign win           = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div  <= '0;
         ridx <= '0;
      end else if (last_div) begin
         div  <= '0;
         ridx <= ridx + 3'd1;
      end else begin
         div  <= div + 16'd1;
      end
   end

   // A write in the swap cycle still targets the old back bank, which becomes the new front.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 8; i++) begin
               bank[b][i] <= '0;
            end
         end
      end else if (wr_en) begin
         bank[~front_sel][wr_row] <= '{r: wr_r, g: wr_g};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         front_sel   <= 1'b0;
         swap_pend   <= 1'b0;
         swap_ack    <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= frame_end;
         swap_ack    <= do_swap;
         if (do_swap) begin
            front_sel <= ~front_sel;
            swap_pend <= 1'b0;
         end else if (swap_req) begin
            swap_pend <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row  <= 8'hFF;
         colR <= '0;
         colG <= '0;
      end else if (lit && win) begin
         row  <= ~(8'b1 << ridx);
         colR <= cur.r;
         colG <= cur.g;
      end else begin
         row  <= 8'hFF;
         colR <= '0;
         colG <= '0;
      end
   end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan with SCAN_DIV=8, BLANK_CYC=2; honours LED_DIM_EN when defined.
module tb_led_matrix_scan;

   logic       clk;
   logic       rst;
   logic       wr_en;
   logic [2:0] wr_row;
   logic [7:0] wr_r;
   logic [7:0] wr_g;
   logic       swap_req;
   logic [2:0] bright;
   logic       swap_pend;
   logic       swap_ack;
   logic       frame_start;
   logic [7:0] row;
   logic [7:0] colR;
   logic [7:0] colG;

   led_matrix_scan #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_r(wr_r), .wr_g(wr_g),
      .swap_req(swap_req), .bright(bright), .swap_pend(swap_pend), .swap_ack(swap_ack),
      .frame_start(frame_start), .row(row), .colR(colR), .colG(colG)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int n;                       // clock edges since reset release
   int ack_at    = -1;
   int pend_from = 0;
   int pend_to   = 0;
   logic [7:0] er [8];          // expected front bank contents
   logic [7:0] eg [8];

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s at n=%0d: got %h expected %h", tag, n, obs, exp);
      end
   endtask

   // Pins at edge n reflect the scan state after n-1 edges.
   task automatic check_pins();
      int m, d, r;
      logic on;
      logic [7:0] xr;
      m  = n - 1;
      d  = m % 8;
      r  = (m / 8) % 8;
      on = (d >= 2);
`ifdef LED_DIM_EN
      on = on && (((d - 2) & 7) <= int'(bright));
`endif
      xr = 8'h01 << r;
      chk("row",  row,  on ? ~xr : 8'hFF);
      chk("colR", colR, on ? er[r] : 8'h00);
      chk("colG", colG, on ? eg[r] : 8'h00);
      chk("frame_start", 8'(frame_start), 8'(n >= 64 && (m % 64) == 63));
      chk("swap_ack", 8'(swap_ack), 8'(n == ack_at));
      chk("swap_pend", 8'(swap_pend), 8'(n >= pend_from && n < pend_to));
   endtask

   task automatic tick();
      @(negedge clk);
      n++;
      check_pins();
   endtask

   task automatic set_front(input logic [7:0] r0, input logic [7:0] g0);
      for (int i = 0; i < 8; i++) begin
         er[i] = r0;
         eg[i] = g0;
      end
   endtask

   initial begin
      rst = 1'b0; wr_en = 1'b0; wr_row = '0; wr_r = '0; wr_g = '0;
      swap_req = 1'b0; bright = 3'd7; n = 0;
      set_front(8'h00, 8'h00);
      @(negedge clk);
      @(negedge clk);
      chk("rst_row", row, 8'hFF);
      chk("rst_colR", colR, 8'h00);
      chk("rst_ack", 8'(swap_ack), 8'h00);
      chk("rst_fs", 8'(frame_start), 8'h00);
      rst = 1'b1;

      // 1: empty banks, first frame_start after 64 edges
      while (n < 64) tick();

      // 2: fill back bank and request a swap
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; wr_row = 3'(i); wr_r = 8'h18; wr_g = 8'h24;
         tick();
      end
      wr_en = 1'b0;
      swap_req = 1'b1; pend_from = 73; pend_to = 128; ack_at = 128;
      tick();
      swap_req = 1'b0;
      while (n < 128) tick();
      set_front(8'h18, 8'h24);
      while (n < 192) tick();

      // 3: three requests inside one frame give one swap
      pend_from = 198; pend_to = 256; ack_at = 256;
      while (n < 256) begin
         swap_req = (n == 197 || n == 210 || n == 230);
         tick();
      end
      swap_req = 1'b0;
      set_front(8'h00, 8'h00);

      // 4: request and write coincide with the frame-end cycle
      while (n < 319) tick();
      swap_req = 1'b1; wr_en = 1'b1; wr_row = 3'd7; wr_r = 8'hFF; wr_g = 8'h00;
      ack_at = 320;
      tick();
      swap_req = 1'b0; wr_en = 1'b0;
      set_front(8'h18, 8'h24);
      er[7] = 8'hFF; eg[7] = 8'h00;
      while (n < 384) tick();

      // 6: reduced brightness for one frame
      bright = 3'd1;
      while (n < 448) tick();
      bright = 3'd7;

      // 5: asynchronous reset while a swap is pending
      swap_req = 1'b1; pend_from = 449; pend_to = 100000;
      tick();
      swap_req = 1'b0;
      while (n < 452) tick();
      #2 rst = 1'b0;
      #1;
      chk("arst_row",  row,  8'hFF);
      chk("arst_colR", colR, 8'h00);
      chk("arst_colG", colG, 8'h00);
      chk("arst_pend", 8'(swap_pend), 8'h00);
      @(negedge clk);
      @(negedge clk);
      chk("arst_hold_ack", 8'(swap_ack), 8'h00);
      rst = 1'b1; n = 0; ack_at = -1; pend_from = 0; pend_to = 0;
      set_front(8'h00, 8'h00);
      while (n < 140) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: bench did not finish, got no end expected end");
      $fatal(1, "timeout");
   end

endmodule
